uart_tx_arbiter: RTL and testbench

Round-robin controller sharing a single uart transmitter between NREQ requesters (debug console, status reporter, command responder, ...). It sits between the requesters and the uart's transmit/data_tx/busy_tx pins and sequences one byte at a time into the uart. Each byte carries a last flag, so a requester keeps the uart locked for a multi-byte packet. A watchdog recovers if the uart never acknowledges a byte.

---
 rtl/uart_ctrl_pkg.sv | 26 ++
 rtl/rr_arbiter.sv | 34 +++
 rtl/uart_tx_arbiter.sv | 160 ++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_ctrl_pkg
// Purpose  : Shared constants for the uart transmit controller family.
// Revision : 1.0
// ============================================================================
package uart_ctrl_pkg;

   localparam int c_byte_w = 8;

   localparam logic [2:0] c_st_idle       = 3'd0;
   localparam logic [2:0] c_st_issue      = 3'd1;
   localparam logic [2:0] c_st_wait_start = 3'd2;
   localparam logic [2:0] c_st_wait_done  = 3'd3;
   localparam logic [2:0] c_st_hold       = 3'd4;

   // Width of a counter able to reach the larger of two timeouts.
   function automatic int cnt_width(input int a, input int b);
      int m;
      m = (a > b) ? a : b;
      if (m < 2) return 1;
      return $clog2(m);
   endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Purpose  : Combinational round-robin pick, searching upward from ptr_i.
// Revision : 1.0
// ============================================================================
module rr_arbiter #(
   parameter int NREQ = 4
) (
   input  logic [NREQ-1:0]         req_i,
   input  logic [$clog2(NREQ)-1:0] ptr_i,
   output logic [NREQ-1:0]         gnt_o,
   output logic [$clog2(NREQ)-1:0] idx_o,
   output logic                    valid_o
);

   always_comb begin
      int j;
      j       = 0;
      gnt_o   = '0;
      idx_o   = '0;
      valid_o = 1'b0;
      for (int off = 0; off < NREQ; off++) begin
         j = (int'(ptr_i) + off) % NREQ;
         if (!valid_o && req_i[j]) begin
            valid_o  = 1'b1;
            gnt_o[j] = 1'b1;
            idx_o    = ($clog2(NREQ))'(j);
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_arbiter
// Purpose  : Round-robin sharing of one uart transmitter with packet locking.
// Revision : 1.0
// ============================================================================
module uart_tx_arbiter
   import uart_ctrl_pkg::*;
#(
   parameter int NREQ          = 4,
   parameter int START_TIMEOUT = 16,
   parameter int HOLD_TIMEOUT  = 65535
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NREQ-1:0]          req,
   input  logic [NREQ-1:0]          req_last,
   input  logic [c_byte_w*NREQ-1:0] req_data,
   output logic [NREQ-1:0]          req_ack,
   output logic [NREQ-1:0]          grant,
   output logic                     uart_transmit,
   output logic [c_byte_w-1:0]      uart_data_tx,
   input  logic                     uart_busy_tx,
   output logic                     timeout_err
);

   localparam int c_iw = $clog2(NREQ);
   localparam int c_cw = cnt_width(START_TIMEOUT, HOLD_TIMEOUT);
   localparam logic [c_cw-1:0] c_start_last = c_cw'(START_TIMEOUT - 1);
   localparam logic [c_cw-1:0] c_hold_last  = c_cw'(HOLD_TIMEOUT - 1);
   localparam logic [c_iw-1:0] c_idx_max    = c_iw'(NREQ - 1);

   logic [2:0]          state_q, state_d;
   logic [NREQ-1:0]     grant_q, grant_d;
   logic [c_iw-1:0]     idx_q,   idx_d;
   logic [c_iw-1:0]     ptr_q,   ptr_d;
   logic                last_q,  last_d;
   logic [c_byte_w-1:0] data_q,  data_d;
   logic [c_cw-1:0]     cnt_q,   cnt_d;
   logic                terr_q,  terr_d;

   logic [NREQ-1:0]     w_arb_gnt;
   logic [c_iw-1:0]     w_arb_idx;
   logic                w_arb_valid;
   logic [c_iw-1:0]     w_next_ptr;
   logic [c_iw-1:0]     w_sel_idx;
   logic [c_byte_w-1:0] w_sel_data;
   logic                w_issue;

   rr_arbiter #(
      .NREQ (NREQ)
   ) u_rr_arbiter (
      .req_i   (req),
      .ptr_i   (ptr_q),
      .gnt_o   (w_arb_gnt),
      .idx_o   (w_arb_idx),
      .valid_o (w_arb_valid)
   );

   // In HOLD only the lock owner may feed the next byte.
   assign w_sel_idx  = (state_q == c_st_hold) ? idx_q : w_arb_idx;
   assign w_sel_data = req_data[c_byte_w*w_sel_idx +: c_byte_w];
   assign w_next_ptr = (idx_q == c_idx_max) ? '0 : idx_q + c_iw'(1);
   assign w_issue    = (state_q == c_st_issue);

   assign uart_transmit = w_issue;
   assign req_ack       = {NREQ{w_issue}} & grant_q;
   assign grant         = grant_q;
   assign uart_data_tx  = data_q;
   assign timeout_err   = terr_q;

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      idx_d   = idx_q;
      ptr_d   = ptr_q;
      last_d  = last_q;
      data_d  = data_q;
      cnt_d   = (cnt_q == '1) ? cnt_q : cnt_q + c_cw'(1);
      terr_d  = 1'b0;
      case (state_q)
         c_st_idle: begin
            // A reset can land mid-frame, so never start while the uart is busy.
            if (w_arb_valid && !uart_busy_tx) begin
               grant_d = w_arb_gnt;
               idx_d   = w_arb_idx;
               data_d  = w_sel_data;
               last_d  = req_last[w_sel_idx];
               state_d = c_st_issue;
            end
         end
         c_st_issue: begin
            cnt_d   = '0;
            state_d = c_st_wait_start;
         end
         c_st_wait_start: begin
            if (uart_busy_tx) begin
               state_d = c_st_wait_done;
            end else if (cnt_q == c_start_last) begin
               terr_d  = 1'b1;
               grant_d = '0;
               ptr_d   = w_next_ptr;
               state_d = c_st_idle;
            end
         end
         c_st_wait_done: begin
            if (!uart_busy_tx) begin
               if (last_q) begin
                  grant_d = '0;
                  ptr_d   = w_next_ptr;
                  state_d = c_st_idle;
               end else begin
                  cnt_d   = '0;
                  state_d = c_st_hold;
               end
            end
         end
         c_st_hold: begin
            if (req[idx_q]) begin
               data_d  = w_sel_data;
               last_d  = req_last[idx_q];
               state_d = c_st_issue;
            end else if (cnt_q == c_hold_last) begin
               terr_d  = 1'b1;
               grant_d = '0;
               ptr_d   = w_next_ptr;
               state_d = c_st_idle;
            end
         end
         default: begin
            grant_d = '0;
            state_d = c_st_idle;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= c_st_idle;
         grant_q <= '0;
         idx_q   <= '0;
         ptr_q   <= '0;
         last_q  <= 1'b0;
         data_q  <= '0;
         cnt_q   <= '0;
         terr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         idx_q   <= idx_d;
         ptr_q   <= ptr_d;
         last_q  <= last_d;
         data_q  <= data_d;
         cnt_q   <= cnt_d;
         terr_q  <= terr_d;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_arbiter
// Purpose  : Scoreboard bench for uart_tx_arbiter with a simple uart model.
// Revision : 1.0
// ============================================================================
module tb_uart_tx_arbiter;

   localparam int NREQ = 4;

   logic            clk;
   logic            rst;
   logic [NREQ-1:0] req;
   logic [NREQ-1:0] req_last;
   logic [8*NREQ-1:0] req_data;
   logic [NREQ-1:0] req_ack;
   logic [NREQ-1:0] grant;
   logic            uart_transmit;
   logic [7:0]      uart_data_tx;
   logic            uart_busy_tx;
   logic            timeout_err;

   uart_tx_arbiter #(
      .NREQ          (NREQ),
      .START_TIMEOUT (16),
      .HOLD_TIMEOUT  (8)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .req           (req),
      .req_last      (req_last),
      .req_data      (req_data),
      .req_ack       (req_ack),
      .grant         (grant),
      .uart_transmit (uart_transmit),
      .uart_data_tx  (uart_data_tx),
      .uart_busy_tx  (uart_busy_tx),
      .timeout_err   (timeout_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int         idx;
      logic [7:0] data;
   } exp_t;

   exp_t       sb[$];
   logic [8:0] rq[NREQ][$];
   int         n_checks = 0;
   int         n_fail   = 0;
   int         cyc      = 0;
   int         tx_count = 0;
   int         tx_cyc   = 0;
   int         terr_count = 0;
   int         rise_cyc[NREQ];
   logic [NREQ-1:0] req_prev = '0;
   int         busy_cnt = 0;
   logic       model_en = 1'b1;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=0x%0h expected=0x%0h (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // uart model: busy rises the cycle after a start pulse and lasts 20 cycles
   always @(posedge clk) begin
      if (uart_transmit && model_en) busy_cnt <= 20;
      else if (busy_cnt != 0)        busy_cnt <= busy_cnt - 1;
   end
   assign uart_busy_tx = (busy_cnt != 0);

   // Monitor, then requester models, all on the falling edge.
   always @(negedge clk) begin
      exp_t e;
      check_eq("grant_onehot", $countones(grant) <= 1, 1);
      check_eq("ack_vs_grant", req_ack, uart_transmit ? grant : '0);
      if (timeout_err) terr_count++;
      if (uart_transmit) begin
         tx_count++;
         tx_cyc = cyc;
         check_eq("tx_while_busy", uart_busy_tx, 0);
         if (sb.size() == 0) begin
            check_eq("sb_unexpected_tx", 1, 0);
         end else begin
            e = sb.pop_front();
            check_eq("tx_data", uart_data_tx, e.data);
            check_eq("tx_grant", grant, 1 << e.idx);
         end
      end
      for (int i = 0; i < NREQ; i++) begin
         if (req_ack[i] && rq[i].size() > 0) void'(rq[i].pop_front());
         if (rq[i].size() > 0) begin
            req[i]             = 1'b1;
            req_data[8*i +: 8] = rq[i][0][7:0];
            req_last[i]        = rq[i][0][8];
         end else begin
            req[i]      = 1'b0;
            req_last[i] = 1'b0;
         end
         if (req[i] && !req_prev[i]) rise_cyc[i] = cyc;
      end
      req_prev = req;
   end

   task automatic send(input int idx, input logic [7:0] d, input logic last);
      rq[idx].push_back({last, d});
   endtask

   task automatic expect_byte(input int idx, input logic [7:0] d);
      exp_t e;
      e.idx  = idx;
      e.data = d;
      sb.push_back(e);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_tx(input int n);
      int target;
      target = tx_count + n;
      for (int k = 0; k < 200 && tx_count < target; k++) tick();
      if (tx_count < target) check_eq("wait_tx_expired", tx_count, target);
   endtask

   task automatic wait_idle();
      bit done;
      done = 1'b0;
      for (int k = 0; k < 400 && !done; k++) begin
         tick();
         done = (sb.size() == 0) && !uart_busy_tx && (grant == '0) &&
                (rq[0].size() == 0) && (rq[1].size() == 0) &&
                (rq[2].size() == 0) && (rq[3].size() == 0);
      end
      check_eq("idle_reached", done, 1);
   endtask

   task automatic wait_terr();
      for (int k = 0; k < 80 && !timeout_err; k++) tick();
      check_eq("timeout_seen", timeout_err, 1);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      check_eq("rst_grant", grant, 0);
      check_eq("rst_transmit", uart_transmit, 0);
      check_eq("rst_data", uart_data_tx, 0);
      check_eq("rst_ack", req_ack, 0);
      check_eq("rst_terr", timeout_err, 0);
      rst = 1'b0;
   endtask

   initial begin
      int t0;
      int terr0;
      req      = '0;
      req_last = '0;
      req_data = '0;
      rst      = 1'b1;
      tick();
      do_reset();

      // single byte from requester 2, then pointer sits at 3
      expect_byte(2, 8'h5A);
      send(2, 8'h5A, 1'b1);
      wait_tx(1);
      check_eq("single_latency", tx_cyc - rise_cyc[2], 1);
      for (int k = 0; k < 25; k++) begin
         tick();
         if (uart_busy_tx) begin
            check_eq("single_grant_hold", grant, 4'b0100);
            check_eq("single_data_hold", uart_data_tx, 8'h5A);
         end
      end
      wait_idle();
      expect_byte(3, 8'h33);
      expect_byte(0, 8'h11);
      send(0, 8'h11, 1'b1);
      send(3, 8'h33, 1'b1);
      wait_idle();

      // round robin with everyone requesting
      do_reset();
      t0 = tx_count;
      for (int i = 0; i < NREQ; i++) begin
         expect_byte(i, 8'hA0 + 8'(i));
         send(i, 8'hA0 + 8'(i), 1'b1);
      end
      expect_byte(0, 8'hB0);
      send(0, 8'hB0, 1'b1);
      wait_idle();
      check_eq("rr_tx_count", tx_count - t0, 5);

      // locked packet from requester 1 blocks requester 0
      do_reset();
      expect_byte(1, 8'h01);
      expect_byte(1, 8'h02);
      expect_byte(1, 8'h03);
      expect_byte(0, 8'hC0);
      send(1, 8'h01, 1'b0);
      send(1, 8'h02, 1'b0);
      send(1, 8'h03, 1'b1);
      wait_tx(1);
      send(0, 8'hC0, 1'b1);
      t0 = tx_count;
      for (int k = 0; k < 200 && tx_count < t0 + 2; k++) begin
         check_eq("lock_grant", grant, 4'b0010);
         tick();
      end
      wait_idle();

      // start timeout: uart never goes busy
      do_reset();
      model_en = 1'b0;
      terr0    = terr_count;
      expect_byte(1, 8'h51);
      expect_byte(2, 8'h52);
      send(1, 8'h51, 1'b1);
      send(2, 8'h52, 1'b1);
      wait_tx(1);
      t0 = tx_cyc;
      wait_terr();
      model_en = 1'b1;
      check_eq("start_to_delay", cyc - t0, 17);
      check_eq("start_to_grant", grant, 0);
      wait_idle();
      check_eq("start_to_count", terr_count - terr0, 1);

      // hold timeout: requester 3 abandons its packet
      do_reset();
      expect_byte(3, 8'h3C);
      expect_byte(0, 8'h0D);
      send(3, 8'h3C, 1'b0);
      wait_tx(1);
      t0 = tx_cyc;
      send(0, 8'h0D, 1'b1);
      wait_terr();
      check_eq("hold_to_delay", cyc - t0, 30);
      check_eq("hold_to_grant", grant, 0);
      wait_idle();

      // reset while the uart is still shifting a frame
      do_reset();
      expect_byte(0, 8'hE1);
      expect_byte(0, 8'hE2);
      send(0, 8'hE1, 1'b1);
      send(0, 8'hE2, 1'b1);
      wait_tx(1);
      repeat (5) tick();
      do_reset();
      t0 = tx_count;
      for (int k = 0; k < 40 && uart_busy_tx; k++) tick();
      check_eq("rst_mid_no_tx", tx_count, t0);
      wait_idle();
      check_eq("rst_mid_resume", tx_count, t0 + 1);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
